// File: rtl/if_icache_unit_pkg.sv
// Shared bus widths, FSM encoding and fetch-output payload for the instruction cache.
package if_icache_unit_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } icache_state_e;

  typedef struct packed {
    logic                   valid;
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
    logic                   pre_take;
  } if_out_t;

endpackage

// File: rtl/if_icache_unit_icache_way.sv
// One cache way: valid/tag/data per set, combinational lookup, single fill port.
module icache_way
  import if_icache_unit_pkg::*;
#(
  parameter int unsigned SETS  = 128,
  parameter int unsigned IDX_W = 7,
  parameter int unsigned TAG_W = 23
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   i_rd_idx,
  input  logic [TAG_W-1:0]   i_rd_tag,
  output logic               o_hit_c,
  output logic [InstBus-1:0] o_data_c,
  input  logic [IDX_W-1:0]   i_fill_idx,
  output logic               o_fill_valid_c,
  input  logic               i_wr_en,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [InstBus-1:0] i_wr_data,
  input  logic               i_flush
);

  logic [SETS-1:0]    r_valid;
  logic [TAG_W-1:0]   r_tag  [SETS];
  logic [InstBus-1:0] r_data [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_fill_idx] <= 1'b1;
    end
  end

  // Storage arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_fill_idx]  <= i_wr_tag;
      r_data[i_fill_idx] <= i_wr_data;
    end
  end

  assign o_hit_c        = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_data_c       = r_data[i_rd_idx];
  assign o_fill_valid_c = r_valid[i_fill_idx];

endmodule

// File: rtl/if_icache_unit.sv
// Instruction-fetch cache: 0-cycle hits, IDLE/REQ/WAIT miss handling, optional 2-way LRU.
// Define ICACHE_PERF_EN to build the hit/miss performance counters.
module if_icache_unit
  import if_icache_unit_pkg::*;
#(
  parameter int unsigned ICACHE_ENTRIES = 128,
  parameter int unsigned ICACHE_WAYS    = 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic [InstAddrBus-1:0] pc_in,
  input  logic                   pre_to_take_in,
  input  logic                   branch_flag_in,
  input  logic                   flush_in,
  output logic                   if_req_out,
  output logic [InstAddrBus-1:0] inst_addr_out,
  input  logic [1:0]             busy_in,
  input  logic [InstBus-1:0]     inst_in,
  input  logic                   inst_done_in,
  output logic [InstAddrBus-1:0] if_pc_out,
  output logic [InstBus-1:0]     if_inst_out,
  output logic                   if_valid_out,
  output logic                   pre_to_take_out,
  output logic                   stall_req_from_if,
  output logic [31:0]            hit_cnt_out,
  output logic [31:0]            miss_cnt_out
);

  localparam int unsigned Sets = ICACHE_ENTRIES / ICACHE_WAYS;
  localparam int unsigned IdxW = $clog2(Sets);
  localparam int unsigned TagW = InstAddrBus - 2 - IdxW;

  icache_state_e r_state, w_next_state;
  logic [InstAddrBus-1:0] r_miss_addr;
  logic                   r_kill;
  logic                   r_drop;

  logic [IdxW-1:0] w_idx, w_miss_idx;
  logic [TagW-1:0] w_tag, w_miss_tag;
  logic [ICACHE_WAYS-1:0] w_hit, w_fill_valid, w_wr_en;
  logic [InstBus-1:0]     w_data [ICACHE_WAYS];
  logic [InstBus-1:0]     w_hit_data;
  logic                   w_hit_way, w_any_hit, w_victim;
  logic                   w_hit_take_c, w_miss_start_c, w_fill_c, w_wr_c, w_flush_c;
  logic                   w_req, w_stall;
  logic [InstAddrBus-1:0] w_req_addr;
  if_out_t                w_out;
  logic                   w_unused;

  assign w_idx      = pc_in[IdxW+1:2];
  assign w_tag      = pc_in[InstAddrBus-1:IdxW+2];
  assign w_miss_idx = r_miss_addr[IdxW+1:2];
  assign w_miss_tag = r_miss_addr[InstAddrBus-1:IdxW+2];
  assign w_wr_c     = rdy_in && w_fill_c;
  assign w_flush_c  = rdy_in && flush_in;
  assign w_any_hit  = |w_hit;

  for (genvar g = 0; g < ICACHE_WAYS; g++) begin : g_way
    icache_way #(
      .SETS  (Sets),
      .IDX_W (IdxW),
      .TAG_W (TagW)
    ) u_way (
      .clk            (clk_in),
      .rst_n          (rst_in),
      .i_rd_idx       (w_idx),
      .i_rd_tag       (w_tag),
      .o_hit_c        (w_hit[g]),
      .o_data_c       (w_data[g]),
      .i_fill_idx     (w_miss_idx),
      .o_fill_valid_c (w_fill_valid[g]),
      .i_wr_en        (w_wr_en[g]),
      .i_wr_tag       (w_miss_tag),
      .i_wr_data      (inst_in),
      .i_flush        (w_flush_c)
    );
    assign w_wr_en[g] = w_wr_c && (w_victim == 1'(g));
  end

  always_comb begin
    w_hit_data = '0;
    w_hit_way  = 1'b0;
    for (int g = 0; g < int'(ICACHE_WAYS); g++) begin
      if (w_hit[g]) begin
        w_hit_data = w_data[g];
        w_hit_way  = 1'(g);
      end
    end
  end

  // LRU bit per set names the least-recently-used way; invalid ways fill first.
  if (ICACHE_WAYS == 2) begin : g_lru
    logic [Sets-1:0] r_lru;

    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        r_lru <= '0;
      end else if (rdy_in) begin
        if (w_fill_c && !flush_in) begin
          r_lru[w_miss_idx] <= ~w_victim;
        end else if (w_hit_take_c) begin
          r_lru[w_idx] <= ~w_hit_way;
        end
      end
    end

    always_comb begin
      w_victim = r_lru[w_miss_idx];
      if (!w_fill_valid[0]) begin
        w_victim = 1'b0;
      end else if (!w_fill_valid[1]) begin
        w_victim = 1'b1;
      end
    end
  end else begin : g_dm
    assign w_victim = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
    end else if (rdy_in) begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_out          = '0;
    w_req          = 1'b0;
    w_req_addr     = '0;
    w_stall        = 1'b0;
    w_hit_take_c   = 1'b0;
    w_miss_start_c = 1'b0;
    w_fill_c       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!branch_flag_in) begin
          if (w_any_hit) begin
            w_hit_take_c   = 1'b1;
            w_out.valid    = 1'b1;
            w_out.pc       = pc_in;
            w_out.inst     = w_hit_data;
            w_out.pre_take = pre_to_take_in;
          end else begin
            w_stall        = 1'b1;
            w_miss_start_c = 1'b1;
            w_next_state   = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        w_req      = 1'b1;
        w_req_addr = r_miss_addr;
        w_stall    = 1'b1;
        if (busy_in[0]) begin
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_stall = 1'b1;
        if (inst_done_in) begin
          w_stall      = 1'b0;
          w_next_state = ST_IDLE;
          w_fill_c     = !r_drop && !flush_in;
          if (!r_kill && !branch_flag_in) begin
            w_out.valid    = 1'b1;
            w_out.pc       = r_miss_addr;
            w_out.inst     = inst_in;
            w_out.pre_take = pre_to_take_in;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    // Outputs stay quiet while reset is held, even if pc_in would miss.
    if (!rst_in) begin
      w_out   = '0;
      w_req   = 1'b0;
      w_stall = 1'b0;
    end
  end

  // Kill hides a redirected fill's output; drop keeps a flushed fill out of the arrays.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_miss_addr <= '0;
      r_kill      <= 1'b0;
      r_drop      <= 1'b0;
    end else if (rdy_in) begin
      if (w_miss_start_c) begin
        r_miss_addr <= pc_in;
      end
      if (w_next_state == ST_IDLE) begin
        r_kill <= 1'b0;
        r_drop <= 1'b0;
      end else begin
        if (branch_flag_in && (r_state != ST_IDLE)) begin
          r_kill <= 1'b1;
        end
        if (flush_in) begin
          r_drop <= 1'b1;
        end
      end
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (rdy_in) begin
      if (w_hit_take_c) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_miss_start_c) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt_out  = r_hit_cnt;
  assign miss_cnt_out = r_miss_cnt;
`else
  assign hit_cnt_out  = '0;
  assign miss_cnt_out = '0;
`endif

  assign if_req_out        = w_req;
  assign inst_addr_out     = w_req_addr;
  assign stall_req_from_if = w_stall;
  assign if_valid_out      = w_out.valid;
  assign if_pc_out         = w_out.pc;
  assign if_inst_out       = w_out.inst;
  assign pre_to_take_out   = w_out.pre_take;

  assign w_unused = ^{busy_in[1], w_fill_valid, w_hit_way, w_hit_take_c};

endmodule

// File: tb/tb_if_icache_unit.sv
// Self-checking bench: direct-mapped and 2-way instances against a recency-list cache model.
module tb_if_icache_unit;

  localparam int ENTRIES = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy[2], pre[2], br[2], fl[2], done[2];
  logic [31:0] pc[2], inst[2];
  logic [1:0]  busy[2];
  logic        req[2], ovalid[2], opre[2], stall[2];
  logic [31:0] iaddr[2], opc[2], oinst[2], hitc[2], missc[2];

  int n_cmp = 0;
  int n_bad = 0;

  // Model: per set, resident line addresses ordered most-recent first.
  logic [31:0] m_line[2][ENTRIES][2];
  logic [31:0] m_data[2][ENTRIES][2];
  int          m_cnt[2][ENTRIES];
  int          m_hits[2], m_miss[2];

  always #5 clk = ~clk;

  if_icache_unit #(.ICACHE_ENTRIES(ENTRIES), .ICACHE_WAYS(1)) u_dut_dm (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy[0]), .pc_in(pc[0]), .pre_to_take_in(pre[0]),
    .branch_flag_in(br[0]), .flush_in(fl[0]), .if_req_out(req[0]), .inst_addr_out(iaddr[0]),
    .busy_in(busy[0]), .inst_in(inst[0]), .inst_done_in(done[0]), .if_pc_out(opc[0]),
    .if_inst_out(oinst[0]), .if_valid_out(ovalid[0]), .pre_to_take_out(opre[0]),
    .stall_req_from_if(stall[0]), .hit_cnt_out(hitc[0]), .miss_cnt_out(missc[0])
  );

  if_icache_unit #(.ICACHE_ENTRIES(ENTRIES), .ICACHE_WAYS(2)) u_dut_2w (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy[1]), .pc_in(pc[1]), .pre_to_take_in(pre[1]),
    .branch_flag_in(br[1]), .flush_in(fl[1]), .if_req_out(req[1]), .inst_addr_out(iaddr[1]),
    .busy_in(busy[1]), .inst_in(inst[1]), .inst_done_in(done[1]), .if_pc_out(opc[1]),
    .if_inst_out(oinst[1]), .if_valid_out(ovalid[1]), .pre_to_take_out(opre[1]),
    .stall_req_from_if(stall[1]), .hit_cnt_out(hitc[1]), .miss_cnt_out(missc[1])
  );

  task automatic chk(input int k, input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL dut%0d %s observed=%h expected=%h", k, tag, got, exp);
    end
  endtask

  function automatic int m_set(input int k, input logic [31:0] a);
    return int'((a >> 2) & 32'(ENTRIES / (k + 1) - 1));
  endfunction

  function automatic void m_clear(input int k);
    for (int s = 0; s < ENTRIES; s++) m_cnt[k][s] = 0;
    m_hits[k] = 0;
    m_miss[k] = 0;
  endfunction

  function automatic bit m_find(input int k, input logic [31:0] a, output int pos);
    int s;
    s   = m_set(k, a);
    pos = 0;
    for (int i = 0; i < m_cnt[k][s]; i++) begin
      if (m_line[k][s][i] == (a & ~32'h3)) begin
        pos = i;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic void m_touch(input int k, input logic [31:0] a, input int pos);
    int s;
    logic [31:0] l, d;
    s = m_set(k, a);
    l = m_line[k][s][pos];
    d = m_data[k][s][pos];
    for (int i = pos; i > 0; i--) begin
      m_line[k][s][i] = m_line[k][s][i-1];
      m_data[k][s][i] = m_data[k][s][i-1];
    end
    m_line[k][s][0] = l;
    m_data[k][s][0] = d;
  endfunction

  function automatic void m_fill(input int k, input logic [31:0] a, input logic [31:0] w);
    int s;
    s = m_set(k, a);
    if (m_cnt[k][s] < k + 1) m_cnt[k][s]++;
    for (int i = m_cnt[k][s] - 1; i > 0; i--) begin
      m_line[k][s][i] = m_line[k][s][i-1];
      m_data[k][s][i] = m_data[k][s][i-1];
    end
    m_line[k][s][0] = a & ~32'h3;
    m_data[k][s][0] = w;
  endfunction

  task automatic chk_perf(input int k);
`ifdef ICACHE_PERF_EN
    chk(k, "hit_cnt", hitc[k], 32'(m_hits[k]));
    chk(k, "miss_cnt", missc[k], 32'(m_miss[k]));
`else
    chk(k, "hit_cnt_tied", hitc[k], 32'd0);
    chk(k, "miss_cnt_tied", missc[k], 32'd0);
`endif
  endtask

  // One fetch on dut k; the other instance is frozen with rdy low.
  task automatic fetch(input int k, input logic [31:0] a, input logic p, input logic [31:0] word,
                       input int bd, input int dd, input bit bw, input bit fw);
    int   pos;
    bit   hit;
    logic [31:0] d;
    @(negedge clk);
    rdy[k] = 1'b1; rdy[1-k] = 1'b0;
    pc[k] = a; pre[k] = p; br[k] = 1'b0; fl[k] = 1'b0; busy[k] = 2'b00; done[k] = 1'b0;
    #1;
    hit = m_find(k, a, pos);
    if (hit) begin
      d = m_data[k][m_set(k, a)][pos];
      chk(k, "hit_valid", 32'(ovalid[k]), 32'd1);
      chk(k, "hit_pc", opc[k], a);
      chk(k, "hit_inst", oinst[k], d);
      chk(k, "hit_pre", 32'(opre[k]), 32'(p));
      chk(k, "hit_stall", 32'(stall[k]), 32'd0);
      chk(k, "hit_req", 32'(req[k]), 32'd0);
      m_touch(k, a, pos);
      m_hits[k]++;
      @(posedge clk);
      return;
    end
    chk(k, "miss_stall", 32'(stall[k]), 32'd1);
    chk(k, "miss_valid", 32'(ovalid[k]), 32'd0);
    chk(k, "miss_req_idle", 32'(req[k]), 32'd0);
    m_miss[k]++;
    @(negedge clk);
    for (int i = 0; i < bd; i++) begin
      rdy[k]  = (i != 0);
      busy[k] = (i == 0) ? 2'b01 : 2'b00;
      #1;
      chk(k, "req_hold", 32'(req[k]), 32'd1);
      chk(k, "req_addr", iaddr[k], a);
      chk(k, "req_stall", 32'(stall[k]), 32'd1);
      @(negedge clk);
    end
    rdy[k]  = 1'b1;
    busy[k] = {1'($urandom_range(0, 1)), 1'b1};
    #1;
    chk(k, "req_accept", 32'(req[k]), 32'd1);
    chk(k, "req_accept_addr", iaddr[k], a);
    @(negedge clk);
    busy[k] = 2'b00;
    for (int i = 0; i < dd; i++) begin
      br[k] = (i == 0) && bw;
      fl[k] = (i == 0) && fw;
      #1;
      chk(k, "wait_req", 32'(req[k]), 32'd0);
      chk(k, "wait_stall", 32'(stall[k]), 32'd1);
      chk(k, "wait_valid", 32'(ovalid[k]), 32'd0);
      @(negedge clk);
      if (fl[k]) m_clear_lines(k);
      br[k] = 1'b0;
      fl[k] = 1'b0;
    end
    done[k] = 1'b1;
    inst[k] = word;
    #1;
    chk(k, "done_stall", 32'(stall[k]), 32'd0);
    chk(k, "done_valid", 32'(ovalid[k]), bw ? 32'd0 : 32'd1);
    chk(k, "done_pc", opc[k], bw ? 32'd0 : a);
    chk(k, "done_inst", oinst[k], bw ? 32'd0 : word);
    chk(k, "done_pre", 32'(opre[k]), bw ? 32'd0 : 32'(p));
    @(posedge clk);
    if (!fw) m_fill(k, a, word);
    #1;
    done[k] = 1'b0;
  endtask

  function automatic void m_clear_lines(input int k);
    for (int s = 0; s < ENTRIES; s++) m_cnt[k][s] = 0;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] tag_pool[4];
    logic [31:0] a;
    tag_pool = '{32'h1000, 32'h2000, 32'h5000, 32'h9000};
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rdy[k] = 1'b0; pre[k] = 1'b1; br[k] = 1'b0; fl[k] = 1'b0; done[k] = 1'b0;
      pc[k] = 32'h0; inst[k] = 32'h0; busy[k] = 2'b00;
      m_clear(k);
    end
    @(negedge clk); @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_req", 32'(req[k]), 32'd0);
      chk(k, "rst_stall", 32'(stall[k]), 32'd0);
      chk(k, "rst_valid", 32'(ovalid[k]), 32'd0);
      chk(k, "rst_pre", 32'(opre[k]), 32'd0);
      chk(k, "rst_pc", opc[k], 32'd0);
      chk(k, "rst_iaddr", iaddr[k], 32'd0);
      chk(k, "rst_hitc", hitc[k], 32'd0);
      chk(k, "rst_missc", missc[k], 32'd0);
    end
    rst_n = 1'b1;

    // Direct-mapped: cold miss, refetch hit, conflict eviction, kill, flush.
    fetch(0, 32'h1000, 1'b0, 32'h0050_0093, 0, 0, 1'b0, 1'b0);
    fetch(0, 32'h1000, 1'b1, 32'h0, 0, 0, 1'b0, 1'b0);
    chk_perf(0);
    fetch(0, 32'h1200, 1'b0, 32'h0010_0113, 1, 1, 1'b0, 1'b0);
    fetch(0, 32'h1000, 1'b0, 32'h0050_0093, 0, 0, 1'b0, 1'b0);
    fetch(0, 32'h2000, 1'b1, 32'h1111_1111, 1, 1, 1'b1, 1'b0);
    fetch(0, 32'h2000, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);
    fetch(0, 32'h3000, 1'b0, 32'h2222_2222, 0, 1, 1'b0, 1'b1);
    fetch(0, 32'h3000, 1'b0, 32'h3333_3333, 0, 0, 1'b0, 1'b0);
    fetch(0, 32'h2000, 1'b1, 32'h4444_4444, 0, 0, 1'b0, 1'b0);

    // Two-way: three tags on one set, LRU victim on the third.
    fetch(1, 32'h1000, 1'b0, 32'h0050_0093, 0, 0, 1'b0, 1'b0);
    fetch(1, 32'h1200, 1'b0, 32'h0010_0113, 0, 0, 1'b0, 1'b0);
    fetch(1, 32'h1000, 1'b1, 32'h0, 0, 0, 1'b0, 1'b0);
    fetch(1, 32'h1200, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);
    fetch(1, 32'h1100, 1'b0, 32'h5555_5555, 0, 0, 1'b0, 1'b0);
    fetch(1, 32'h1200, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);
    fetch(1, 32'h1000, 1'b0, 32'h0050_0093, 0, 0, 1'b0, 1'b0);
    chk_perf(0);
    chk_perf(1);

    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 60; r++) begin
        int bd, dd;
        bit bw, fw;
        a  = tag_pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3) << 2) | 32'($urandom_range(0, 3));
        bd = $urandom_range(0, 2);
        dd = $urandom_range(0, 2);
        bw = ($urandom_range(0, 7) == 0);
        fw = ($urandom_range(0, 9) == 0);
        if ((bw || fw) && dd == 0) dd = 1;
        fetch(k, a, 1'($urandom_range(0, 1)), $urandom, bd, dd, bw, fw);
      end
      chk_perf(k);
    end

    // Reset in the middle of a fill; a late return strobe must be ignored.
    @(negedge clk);
    rdy[0] = 1'b1; rdy[1] = 1'b0; pc[0] = 32'h4000; busy[0] = 2'b00; done[0] = 1'b0;
    #1 chk(0, "rstw_miss_stall", 32'(stall[0]), 32'd1);
    @(negedge clk); busy[0] = 2'b01;
    #1 chk(0, "rstw_req", 32'(req[0]), 32'd1);
    @(negedge clk); busy[0] = 2'b00;
    #1 chk(0, "rstw_wait_stall", 32'(stall[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk(0, "rstw_req0", 32'(req[0]), 32'd0);
    chk(0, "rstw_stall0", 32'(stall[0]), 32'd0);
    chk(0, "rstw_valid0", 32'(ovalid[0]), 32'd0);
    chk(0, "rstw_iaddr0", iaddr[0], 32'd0);
    m_clear(0);
    m_clear(1);
    chk_perf(0);
    @(negedge clk);
    rst_n = 1'b1; rdy[0] = 1'b0; done[0] = 1'b1; inst[0] = 32'hDEAD_BEEF;
    #1;
    chk(0, "stray_valid", 32'(ovalid[0]), 32'd0);
    chk(0, "stray_inst", oinst[0], 32'd0);
    chk(0, "stray_stall", 32'(stall[0]), 32'd1);
    @(posedge clk); #1 done[0] = 1'b0;
    fetch(0, 32'h4000, 1'b0, 32'h6666_6666, 0, 0, 1'b0, 1'b0);
    fetch(0, 32'h1000, 1'b0, 32'h0050_0093, 0, 0, 1'b0, 1'b0);
    fetch(0, 32'h4000, 1'b1, 32'h0, 0, 0, 1'b0, 1'b0);
    chk_perf(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_icache_unit.md
IF_ICACHE_UNIT -- requirements
Module: if_icache_unit

Interface
REQ-001 SHALL have parameter ICACHE_ENTRIES, default 128, total cached instructions; power of two, 16..1024.
REQ-002 SHALL have parameter ICACHE_WAYS, default 1, associativity; legal values 1 or 2.
REQ-003 SHALL have port clk_in  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy_in  input  1  global ready; low freezes all state.
REQ-006 SHALL have ports pc_in  input  32  fetch address; pre_to_take_in  input  1  predictor bit for pc_in.
REQ-007 SHALL have ports branch_flag_in  input  1  pipeline redirect; flush_in  input  1  invalidate whole cache (fence.i).
REQ-008 SHALL have ports if_req_out  output  1  memory fetch request; inst_addr_out  output  32  fetch address.
REQ-009 SHALL have ports busy_in  input  2  bit0 = memory controller has accepted/serving the fetch; inst_in  input  32  returned word; inst_done_in  input  1  one-cycle return strobe.
REQ-010 SHALL have ports if_pc_out  output  32; if_inst_out  output  32; if_valid_out  output  1; pre_to_take_out  output  1; stall_req_from_if  output  1.
REQ-011 SHALL have ports hit_cnt_out  output  32; miss_cnt_out  output  32.

Function
REQ-012 SHALL index with pc_in[IDX+1:2], IDX = log2(ICACHE_ENTRIES/ICACHE_WAYS); tag = remaining upper bits; pc_in[1:0] ignored.
REQ-013 SHALL keep one valid bit per line; a hit requires valid and tag match in any way.
REQ-014 SHALL, on hit in IDLE with branch_flag_in low, drive if_valid_out=1, if_pc_out=pc_in, if_inst_out=data, pre_to_take_out=pre_to_take_in combinationally in the same cycle (0-cycle latency), stall_req_from_if=0.
REQ-015 SHALL use FSM IDLE, REQ, WAIT; IDLE->REQ on miss at an edge, latching miss_addr=pc_in; stall_req_from_if=1 combinationally from the miss cycle until fill.
REQ-016 SHALL, in REQ, hold if_req_out=1, inst_addr_out=miss_addr until busy_in[0]=1, then go to WAIT with if_req_out=0.
REQ-017 SHALL, in WAIT with inst_done_in=1, output inst_in on if_inst_out, if_pc_out=miss_addr, if_valid_out=1, stall=0 that cycle, write the line at the edge, return to IDLE.
REQ-018 SHALL, when branch_flag_in=1, force if_valid_out=0, if_pc_out=0, if_inst_out=0, pre_to_take_out=0 that cycle.
REQ-019 SHALL, on branch_flag_in during REQ/WAIT, set kill flag: fill still completes and writes the cache, but no output is produced and kill clears on return to IDLE.
REQ-020 SHALL, on flush_in=1, clear all valid bits at the edge; a fill in progress completes but is not written.
REQ-021 SHALL, when ICACHE_WAYS=2, keep one LRU bit per set: hit or fill marks the used way MRU; fill victim = invalid way first (way0 preferred), else LRU way.
REQ-022 SHALL treat fill and flush on the same edge as flush-wins.
REQ-023 SHALL, with rdy_in=0, hold FSM, arrays, LRU, counters; combinational outputs still follow inputs.
REQ-024 SHALL drive all data outputs zero when if_valid_out=0.

Reset
REQ-025 SHALL on rst_in=0 asynchronously: FSM=IDLE, all valid=0, LRU=0, kill=0, miss_addr=0, counters=0; outputs if_req_out=0, stall_req_from_if=0, if_valid_out=0, all buses 0.
REQ-026 SHALL abandon any outstanding fetch on reset; a later inst_done_in in IDLE is ignored.

Configuration
REQ-027 SHALL, with ICACHE_PERF_EN defined, count hits (REQ-014 cycles with rdy_in=1, advanced at edge) in hit_cnt_out and misses (IDLE->REQ transitions) in miss_cnt_out, both wrapping at 2^32.
REQ-028 SHALL, without ICACHE_PERF_EN, tie hit_cnt_out and miss_cnt_out to 0 and synthesise no counter logic.

Structure
REQ-029 SHALL place FSM state encoding and width constants (InstAddrBus, InstBus) in the shared defines include, not in the module.
REQ-030 SHALL implement tag/valid/data storage as one sub-module icache_way, instantiated ICACHE_WAYS times; FSM, LRU, counters stay in the top.

Verification
REQ-031 SHALL cover: cold miss pc=0x1000, busy_in[0]=1 next cycle, done with inst 0x00500093 -> if_req_out 1 cycle, stall until done, output pc 0x1000 inst 0x00500093.
REQ-032 SHALL cover: refetch pc=0x1000 -> same-cycle if_valid_out=1 inst 0x00500093, no if_req_out, hit_cnt +1 (PERF on).
REQ-033 SHALL cover: WAYS=1, ENTRIES=128, pc 0x1000 then 0x1200 (same index) -> second misses and evicts; 0x1000 misses again. WAYS=2: all three hit after fills except LRU victim on third distinct tag 0x1100.
REQ-034 SHALL cover: branch_flag_in pulse during WAIT -> no valid output at done; next fetch of miss_addr hits.
REQ-035 SHALL cover: flush_in during WAIT then refetch same pc -> miss; rst_in low mid-WAIT -> outputs zero immediately, stray inst_done_in ignored.
